// File: rtl/tlk2711_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlk2711_arb_pkg
// Description : Shared constants for the TLK2711 HP read-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package tlk2711_arb_pkg;

    localparam int c_LEN_W   = 8;
    localparam int c_SIZE_W  = 3;
    localparam int c_BURST_W = 2;
    localparam int c_CACHE_W = 4;
    localparam int c_PROT_W  = 3;
    localparam int c_USER_W  = 4;
    localparam int c_RESP_W  = 2;

    localparam int         c_ST_W     = 2;
    localparam logic [1:0] c_ST_ARB   = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

endpackage
`default_nettype wire

// File: rtl/hp_rr_sel2.sv
`default_nettype none
// ============================================================================
// Module      : hp_rr_sel2
// Description : Two-request round-robin select; ties go to the side that did
//               not win last time.
// Revision    : 1.0 - initial release
// ============================================================================
module hp_rr_sel2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_any,
    output logic o_sel
);

    assign o_any = i_req0 | i_req1;
    assign o_sel = (i_req0 & i_req1) ? ~i_last_grant : i_req1;

endmodule
`default_nettype wire

// File: rtl/tlk2711_hp_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : tlk2711_hp_rd_arb
// Description : Round-robin AXI4 read arbiter sharing one HP read port
//               between the TLK2711-B (s0) and TLK2711-A (s1) DMA masters.
// Revision    : 1.0 - initial release
// ============================================================================
module tlk2711_hp_rd_arb
    import tlk2711_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_OUT    = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,

    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [c_LEN_W-1:0]    s0_arlen,
    input  logic [c_SIZE_W-1:0]   s0_arsize,
    input  logic [c_BURST_W-1:0]  s0_arburst,
    input  logic [c_CACHE_W-1:0]  s0_arcache,
    input  logic [c_PROT_W-1:0]   s0_arprot,
    input  logic [ID_WIDTH-1:0]   s0_arid,
    input  logic [c_USER_W-1:0]   s0_aruser,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic [c_RESP_W-1:0]   s0_rresp,
    output logic                  s0_rlast,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,

    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [c_LEN_W-1:0]    s1_arlen,
    input  logic [c_SIZE_W-1:0]   s1_arsize,
    input  logic [c_BURST_W-1:0]  s1_arburst,
    input  logic [c_CACHE_W-1:0]  s1_arcache,
    input  logic [c_PROT_W-1:0]   s1_arprot,
    input  logic [ID_WIDTH-1:0]   s1_arid,
    input  logic [c_USER_W-1:0]   s1_aruser,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic [c_RESP_W-1:0]   s1_rresp,
    output logic                  s1_rlast,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,

    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [c_LEN_W-1:0]    m_arlen,
    output logic [c_SIZE_W-1:0]   m_arsize,
    output logic [c_BURST_W-1:0]  m_arburst,
    output logic [c_CACHE_W-1:0]  m_arcache,
    output logic [c_PROT_W-1:0]   m_arprot,
    output logic [ID_WIDTH-1:0]   m_arid,
    output logic [c_USER_W-1:0]   m_aruser,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [c_RESP_W-1:0]   m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,

    output logic                  o_owner,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam logic [3:0] c_MAX_OUT = 4'(MAX_OUT);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_nxt;
    logic              r_owner;
    logic              r_last_grant;
    logic [3:0]        r_out_cnt;
    logic [3:0]        r_iss_cnt;
    logic              r_err;

    logic              w_any;
    logic              w_sel;
    logic              w_issue;
    logic              w_route;
    logic              w_own_arvalid;
    logic              w_own_rready;
    logic              w_ar_hs;
    logic              w_rl_hs;
    logic [3:0]        w_iss_inc;

    hp_rr_sel2 u_rr_sel (
        .i_req0       (s0_arvalid),
        .i_req1       (s1_arvalid),
        .i_last_grant (r_last_grant),
        .o_any        (w_any),
        .o_sel        (w_sel)
    );

    assign w_issue       = (r_state == c_ST_ISSUE);
    assign w_route       = (r_state != c_ST_ARB);
    assign w_own_arvalid = r_owner ? s1_arvalid : s0_arvalid;
    assign w_own_rready  = r_owner ? s1_rready  : s0_rready;

    // AR payload always follows the owner; it only matters while m_arvalid is high
    assign m_araddr  = r_owner ? s1_araddr  : s0_araddr;
    assign m_arlen   = r_owner ? s1_arlen   : s0_arlen;
    assign m_arsize  = r_owner ? s1_arsize  : s0_arsize;
    assign m_arburst = r_owner ? s1_arburst : s0_arburst;
    assign m_arcache = r_owner ? s1_arcache : s0_arcache;
    assign m_arprot  = r_owner ? s1_arprot  : s0_arprot;
    assign m_arid    = r_owner ? s1_arid    : s0_arid;
    assign m_aruser  = r_owner ? s1_aruser  : s0_aruser;
    assign m_arvalid = w_issue & w_own_arvalid;

    assign s0_arready = w_issue & ~r_owner & m_arready;
    assign s1_arready = w_issue &  r_owner & m_arready;

    // Outside a grant every stray beat is accepted so the HP port never stalls
    assign m_rready  = w_route ? w_own_rready : 1'b1;
    assign s0_rvalid = w_route & ~r_owner & m_rvalid;
    assign s1_rvalid = w_route &  r_owner & m_rvalid;
    assign s0_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s0_rlast  = m_rlast;
    assign s1_rdata  = m_rdata;
    assign s1_rresp  = m_rresp;
    assign s1_rlast  = m_rlast;

    assign w_ar_hs   = m_arvalid & m_arready;
    assign w_rl_hs   = m_rvalid & m_rready & m_rlast;
    assign w_iss_inc = r_iss_cnt + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_ARB: begin
                if (w_any) w_state_nxt = c_ST_ISSUE;
            end
            c_ST_ISSUE: begin
                if ((w_ar_hs && (w_iss_inc == c_MAX_OUT)) ||
                    (!w_own_arvalid && (r_iss_cnt != 4'd0)))
                    w_state_nxt = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if ((r_out_cnt == 4'd0) || ((r_out_cnt == 4'd1) && w_rl_hs))
                    w_state_nxt = c_ST_ARB;
            end
            default: w_state_nxt = c_ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= c_ST_ARB;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_out_cnt    <= 4'd0;
            r_iss_cnt    <= 4'd0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if ((r_state == c_ST_ARB) && w_any) begin
                r_owner   <= w_sel;
                r_iss_cnt <= 4'd0;
            end else if (w_ar_hs) begin
                r_iss_cnt <= w_iss_inc;
            end

            if ((r_state == c_ST_DRAIN) && (w_state_nxt == c_ST_ARB))
                r_last_grant <= r_owner;

            // Unmatched RLAST flags an error and clamps the counter at zero
            if (w_rl_hs && (r_out_cnt == 4'd0))
                r_err <= 1'b1;

            if (w_ar_hs && !w_rl_hs)
                r_out_cnt <= r_out_cnt + 4'd1;
            else if (!w_ar_hs && w_rl_hs && (r_out_cnt != 4'd0))
                r_out_cnt <= r_out_cnt - 4'd1;
        end
    end

    assign o_owner = r_owner;
    assign o_busy  = (r_state != c_ST_ARB);
    assign o_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tlk2711_hp_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlk2711_hp_rd_arb
// Description : Directed self-checking bench for the HP read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlk2711_hp_rd_arb;

    localparam int AW = 40;
    localparam int DW = 128;
    localparam int IW = 4;

    logic          clk;
    logic          arst_n;
    logic [AW-1:0] s0_araddr,  s1_araddr,  m_araddr;
    logic [7:0]    s0_arlen,   s1_arlen,   m_arlen;
    logic [2:0]    s0_arsize,  s1_arsize,  m_arsize;
    logic [1:0]    s0_arburst, s1_arburst, m_arburst;
    logic [3:0]    s0_arcache, s1_arcache, m_arcache;
    logic [2:0]    s0_arprot,  s1_arprot,  m_arprot;
    logic [IW-1:0] s0_arid,    s1_arid,    m_arid;
    logic [3:0]    s0_aruser,  s1_aruser,  m_aruser;
    logic          s0_arvalid, s1_arvalid, m_arvalid;
    logic          s0_arready, s1_arready, m_arready;
    logic [DW-1:0] s0_rdata,   s1_rdata,   m_rdata;
    logic [1:0]    s0_rresp,   s1_rresp,   m_rresp;
    logic          s0_rlast,   s1_rlast,   m_rlast;
    logic          s0_rvalid,  s1_rvalid,  m_rvalid;
    logic          s0_rready,  s1_rready,  m_rready;
    logic          o_owner, o_busy, o_err;

    int checks = 0;
    int errors = 0;

    tlk2711_hp_rd_arb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .MAX_OUT    (4)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .s0_araddr  (s0_araddr),  .s0_arlen  (s0_arlen),  .s0_arsize (s0_arsize),
        .s0_arburst (s0_arburst), .s0_arcache(s0_arcache),.s0_arprot (s0_arprot),
        .s0_arid    (s0_arid),    .s0_aruser (s0_aruser), .s0_arvalid(s0_arvalid),
        .s0_arready (s0_arready), .s0_rdata  (s0_rdata),  .s0_rresp  (s0_rresp),
        .s0_rlast   (s0_rlast),   .s0_rvalid (s0_rvalid), .s0_rready (s0_rready),
        .s1_araddr  (s1_araddr),  .s1_arlen  (s1_arlen),  .s1_arsize (s1_arsize),
        .s1_arburst (s1_arburst), .s1_arcache(s1_arcache),.s1_arprot (s1_arprot),
        .s1_arid    (s1_arid),    .s1_aruser (s1_aruser), .s1_arvalid(s1_arvalid),
        .s1_arready (s1_arready), .s1_rdata  (s1_rdata),  .s1_rresp  (s1_rresp),
        .s1_rlast   (s1_rlast),   .s1_rvalid (s1_rvalid), .s1_rready (s1_rready),
        .m_araddr   (m_araddr),   .m_arlen   (m_arlen),   .m_arsize  (m_arsize),
        .m_arburst  (m_arburst),  .m_arcache (m_arcache), .m_arprot  (m_arprot),
        .m_arid     (m_arid),     .m_aruser  (m_aruser),  .m_arvalid (m_arvalid),
        .m_arready  (m_arready),  .m_rdata   (m_rdata),   .m_rresp   (m_rresp),
        .m_rlast    (m_rlast),    .m_rvalid  (m_rvalid),  .m_rready  (m_rready),
        .o_owner    (o_owner),
        .o_busy     (o_busy),
        .o_err      (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s0_araddr = '0; s0_arlen = '0; s0_arsize = 3'd4; s0_arburst = 2'd1;
        s0_arcache = '0; s0_arprot = '0; s0_arid = '0; s0_aruser = '0;
        s1_araddr = '0; s1_arlen = '0; s1_arsize = 3'd4; s1_arburst = 2'd1;
        s1_arcache = '0; s1_arprot = '0; s1_arid = '0; s1_aruser = '0;
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        s0_rready = 1'b1; s1_rready = 1'b1;
        m_arready = 1'b1; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        arst_n = 1'b0;
        cyc();
        cyc();
        arst_n = 1'b1;
        cyc();
    endtask

    task automatic wait_grant(input string name);
        for (int k = 0; k < 8 && m_arvalid !== 1'b1; k++) cyc();
        checks++;
        if (m_arvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s_grant_timeout m_arvalid got %0b exp 1", name, m_arvalid);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 16 && o_busy !== 1'b0; k++) cyc();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout o_busy got %0b exp 0", name, o_busy);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        arst_n = 1'b0;
        cyc();
        checks++;
        if (m_arvalid !== 1'b0) begin errors++; $display("FAIL rst_m_arvalid got %0b exp 0", m_arvalid); end
        checks++;
        if (m_rready !== 1'b1) begin errors++; $display("FAIL rst_m_rready got %0b exp 1", m_rready); end
        checks++;
        if ({s0_arready, s1_arready, s0_rvalid, s1_rvalid} !== 4'b0000) begin
            errors++; $display("FAIL rst_slave_outs got %b exp 0000", {s0_arready, s1_arready, s0_rvalid, s1_rvalid});
        end
        checks++;
        if ({o_owner, o_busy, o_err} !== 3'b000) begin
            errors++; $display("FAIL rst_status got %b exp 000", {o_owner, o_busy, o_err});
        end
        arst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_burst();
        logic [DW-1:0] pat;
        do_reset();
        s0_araddr = 40'h12_3456_7000; s0_arlen = 8'd3; s0_arid = 4'h5; s0_arvalid = 1'b1;
        #1;
        checks++;
        if (m_arvalid !== 1'b0) begin errors++; $display("FAIL single_arb_arvalid got %0b exp 0", m_arvalid); end
        cyc();
        checks++;
        if (m_arvalid !== 1'b1) begin errors++; $display("FAIL single_latency got %0b exp 1", m_arvalid); end
        checks++;
        if ({m_araddr, m_arlen, m_arid} !== {40'h12_3456_7000, 8'd3, 4'h5}) begin
            errors++; $display("FAIL single_ar_payload got %h %h %h", m_araddr, m_arlen, m_arid);
        end
        checks++;
        if ({s0_arready, s1_arready, o_owner, o_busy} !== 4'b1001) begin
            errors++; $display("FAIL single_ready got %b exp 1001", {s0_arready, s1_arready, o_owner, o_busy});
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            s0_arvalid = 1'b0;
            pat = 128'hC0DE_0000 + 128'(i);
            m_rvalid = 1'b1; m_rdata = pat; m_rlast = (i == 3); m_rresp = 2'(i);
            #1;
            checks++;
            if ({s0_rvalid, s1_rvalid, m_rready} !== 3'b101 || s0_rdata !== pat || s0_rresp !== 2'(i)) begin
                errors++; $display("FAIL single_beat%0d rv0/rv1/rr %b data %h", i, {s0_rvalid, s1_rvalid, m_rready}, s0_rdata);
            end
        end
        cyc();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_err} !== 2'b00) begin errors++; $display("FAIL single_busy_fall got %b exp 00", {o_busy, o_err}); end
    endtask

    task automatic test_tie_alternation();
        do_reset();
        s0_araddr = 40'hA0; s1_araddr = 40'hB0; s0_arvalid = 1'b1; s1_arvalid = 1'b1;
        wait_grant("tie1");
        checks++;
        if ({o_owner, m_araddr, s1_arready} !== {1'b0, 40'hA0, 1'b0}) begin
            errors++; $display("FAIL tie_first_s0 owner %0b addr %h s1rdy %0b", o_owner, m_araddr, s1_arready);
        end
        cyc();
        s0_arvalid = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1;
        #1;
        checks++;
        if ({s0_rvalid, s1_rvalid} !== 2'b10) begin errors++; $display("FAIL tie_route_s0 got %b exp 10", {s0_rvalid, s1_rvalid}); end
        cyc();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        wait_grant("tie2");
        checks++;
        if ({o_owner, m_araddr, s1_arready} !== {1'b1, 40'hB0, 1'b1}) begin
            errors++; $display("FAIL tie_second_s1 owner %0b addr %h s1rdy %0b", o_owner, m_araddr, s1_arready);
        end
        cyc();
        s1_arvalid = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1;
        #1;
        checks++;
        if ({s0_rvalid, s1_rvalid} !== 2'b01) begin errors++; $display("FAIL tie_route_s1 got %b exp 01", {s0_rvalid, s1_rvalid}); end
        cyc();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        wait_idle("tie");
        s0_arvalid = 1'b1; s1_arvalid = 1'b1;
        wait_grant("tie3");
        checks++;
        if (o_owner !== 1'b0) begin errors++; $display("FAIL tie_repeat_s0 owner got %0b exp 0", o_owner); end
        cyc();
        s0_arvalid = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1;
        cyc();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        wait_grant("tie4");
        cyc();
        s1_arvalid = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1;
        cyc();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        wait_idle("tie_end");
    endtask

    task automatic test_max_out();
        do_reset();
        s0_arvalid = 1'b1; s1_arvalid = 1'b1; s1_araddr = 40'hF00;
        wait_grant("max");
        for (int i = 0; i < 4; i++) begin
            s0_araddr = 40'h1000 + 40'(i * 256);
            #1;
            checks++;
            if ({m_arvalid, s0_arready, s1_arready} !== 3'b110 || m_araddr !== 40'h1000 + 40'(i * 256)) begin
                errors++; $display("FAIL max_ar%0d vld/rdy0/rdy1 %b addr %h", i, {m_arvalid, s0_arready, s1_arready}, m_araddr);
            end
            cyc();
        end
        #1;
        checks++;
        if ({m_arvalid, s0_arready} !== 2'b00) begin
            errors++; $display("FAIL max_cap got vld/rdy %b exp 00", {m_arvalid, s0_arready});
        end
        s0_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_rvalid = 1'b1; m_rlast = 1'b1;
            #1;
            checks++;
            if ({s1_arready, s0_rvalid, o_busy} !== 3'b011) begin
                errors++; $display("FAIL max_drain%0d s1rdy/rv0/busy %b exp 011", i, {s1_arready, s0_rvalid, o_busy});
            end
            cyc();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        checks++;
        if ({o_busy, m_arvalid, s1_arready} !== 3'b000) begin
            errors++; $display("FAIL max_turnaround_arb got %b exp 000", {o_busy, m_arvalid, s1_arready});
        end
        cyc();
        checks++;
        if ({o_owner, m_arvalid, s1_arready} !== 3'b111 || m_araddr !== 40'hF00) begin
            errors++; $display("FAIL max_s1_grant got %b addr %h", {o_owner, m_arvalid, s1_arready}, m_araddr);
        end
        cyc();
        s1_arvalid = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1;
        cyc();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        wait_idle("max_end");
    endtask

    task automatic test_overlap_rlast();
        do_reset();
        s0_arvalid = 1'b1; s0_araddr = 40'h2000;
        wait_grant("ovl");
        cyc();
        s0_araddr = 40'h3000; m_rvalid = 1'b1; m_rlast = 1'b1;
        #1;
        checks++;
        if ({s0_arready, s0_rvalid, m_rready} !== 3'b111) begin
            errors++; $display("FAIL ovl_same_cycle got %b exp 111", {s0_arready, s0_rvalid, m_rready});
        end
        cyc();
        s0_arvalid = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({o_busy, m_arvalid} !== 2'b10) begin
            errors++; $display("FAIL ovl_drain_wait got busy/vld %b exp 10", {o_busy, m_arvalid});
        end
        m_rvalid = 1'b1; m_rlast = 1'b1;
        #1;
        checks++;
        if (s0_rvalid !== 1'b1) begin errors++; $display("FAIL ovl_last_beat got %0b exp 1", s0_rvalid); end
        cyc();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_err} !== 2'b00) begin errors++; $display("FAIL ovl_done got busy/err %b exp 00", {o_busy, o_err}); end
    endtask

    task automatic test_stray_beat();
        do_reset();
        m_rvalid = 1'b1; m_rlast = 1'b1;
        #1;
        checks++;
        if ({m_rready, s0_rvalid, s1_rvalid, o_err} !== 4'b1000) begin
            errors++; $display("FAIL stray_sink got %b exp 1000", {m_rready, s0_rvalid, s1_rvalid, o_err});
        end
        cyc();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        checks++;
        if ({o_err, o_busy} !== 2'b10) begin errors++; $display("FAIL stray_err_set got err/busy %b exp 10", {o_err, o_busy}); end
        cyc();
        cyc();
        checks++;
        if (o_err !== 1'b1) begin errors++; $display("FAIL stray_err_sticky got %0b exp 1", o_err); end
    endtask

    // Runs straight after the stray test so the async reset also clears o_err
    task automatic test_async_reset();
        s1_arvalid = 1'b1; s1_arlen = 8'd7; m_arready = 1'b0;
        wait_grant("areset");
        m_rvalid = 1'b1;
        #1;
        checks++;
        if ({o_owner, m_arvalid, s1_rvalid, o_err} !== 4'b1111) begin
            errors++; $display("FAIL areset_pre got %b exp 1111", {o_owner, m_arvalid, s1_rvalid, o_err});
        end
        #1;
        arst_n = 1'b0;
        #1;
        checks++;
        if ({m_arvalid, s1_rvalid, s1_arready, o_busy, o_err, o_owner, m_rready} !== 7'b0000001) begin
            errors++; $display("FAIL areset_immediate got %b exp 0000001",
                               {m_arvalid, s1_rvalid, s1_arready, o_busy, o_err, o_owner, m_rready});
        end
        idle_inputs();
        cyc();
        arst_n = 1'b1;
        cyc();
        s0_arvalid = 1'b1; s1_arvalid = 1'b1;
        wait_grant("areset_tie");
        checks++;
        if (o_owner !== 1'b0) begin errors++; $display("FAIL areset_tie_s0 owner got %0b exp 0", o_owner); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_tie_alternation();
        test_max_out();
        test_overlap_rlast();
        test_stray_beat();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tlk2711_hp_rd_arb.md
# tlk2711_hp_rd_arb

Two-master AXI4 read arbiter that shares one MPSoC HP slave read port between the TLK2711-B and TLK2711-A transmit DMA engines. It sits between the tlk2711 wrapper's read masters and the mpsoc HP port, in the 100 MHz fabric domain. It grants the AR channel round-robin and holds ownership until every burst issued by the owner has returned its RLAST. R beats are routed back to the owner only.

## Interface
- ADDR_WIDTH, 40, AR address width
- DATA_WIDTH, 128, R data width
- ID_WIDTH, 4, ARID width (passed through unmodified)
- MAX_OUT, 4, max bursts one owner may issue per grant (1..15)
- clk  in  1  fabric clock (100 MHz)
- arst_n  in  1  reset; one clock; reset is asynchronous and active-low
- s0_ar{addr,len,size,burst,cache,prot,id,user}  in  AXI4 widths  TLK2711-B AR payload (addr ADDR_WIDTH, len 8, size 3, burst 2, cache 4, prot 3, id ID_WIDTH, user 4)
- s0_arvalid  in  1 / s0_arready  out  1  TLK2711-B AR handshake
- s0_rdata  out  DATA_WIDTH / s0_rresp  out  2 / s0_rlast  out  1 / s0_rvalid  out  1  R to TLK2711-B
- s0_rready  in  1  TLK2711-B R ready
- s1_*  same set as s0_*  TLK2711-A master
- m_ar{addr,len,size,burst,cache,prot,id,user}  out  AXI4 widths  AR payload to HP port
- m_arvalid  out  1 / m_arready  in  1  HP AR handshake
- m_rdata  in  DATA_WIDTH / m_rresp  in  2 / m_rlast  in  1 / m_rvalid  in  1 / m_rready  out  1  HP R channel
- o_owner  out  1  current/last owner (0 = s0, 1 = s1)
- o_busy  out  1  state != ARB
- o_err  out  1  sticky: RLAST beat received with outstanding count 0

## Operation
- States: ARB, ISSUE, DRAIN. Registers: state, owner, last_grant, out_cnt (4 bit), iss_cnt (4 bit), err.
- ARB: if either arvalid high, owner <= requester; both high -> owner <= ~last_grant. Next state ISSUE, iss_cnt <= 0. m_rready = 1 (stray beats sunk).
- ISSUE: m_ar* and m_arvalid = owner's; owner arready = m_arready; other master arready = 0. AR handshake -> iss_cnt++, out_cnt++.
  - Leave to DRAIN after a handshake making iss_cnt == MAX_OUT, or in any cycle with owner arvalid low and iss_cnt >= 1.
- DRAIN: m_arvalid = 0, both arready = 0.
- R routing (ISSUE and DRAIN): owner rvalid = m_rvalid, owner rdata/rresp/rlast = m_*, m_rready = owner rready; non-owner rvalid = 0.
- out_cnt: +1 on AR handshake, -1 on R handshake with m_rlast; both same cycle -> unchanged.
- DRAIN with out_cnt == 1 and rlast handshake, or out_cnt == 0 -> ARB, last_grant <= owner.
- RLAST handshake with out_cnt == 0 (any state) -> err <= 1, out_cnt stays 0 (no underflow). Cleared only by reset.
- Payload to non-owner outputs is don't-care; drive from m_r* for minimum muxing.

## Timing
- Reset values: state ARB, owner 0, last_grant 1 (s0 wins first tie), out_cnt 0, iss_cnt 0, err 0; all arready/rvalid/m_arvalid 0, m_rready 1, o_busy 0.
- Grant latency: arvalid seen in ARB cycle N -> m_arvalid high cycle N+1.
- AR and R paths combinational through the block; no added beat latency, no bubbles within a burst.
- Return to ARB: cycle after final RLAST handshake; next grant one cycle later (2-cycle turnaround).
- arst_n asserted mid-burst: all outputs to reset values immediately (async); in-flight HP beats are the system's responsibility.

## Structure
- Package tlk2711_arb_pkg: state enum (ARB/ISSUE/DRAIN), AXI field width constants (LEN 8, SIZE 3, BURST 2, CACHE 4, PROT 3, USER 4, RESP 2).
- One sub-module: hp_rr_sel2 (two-request round-robin select from last_grant, combinational).

## Test plan
- Reset, s0 AR arlen=3 -> m_arvalid next cycle, 4 beats reach s0 only, s1_rvalid stays 0, o_busy falls cycle after RLAST.
- s0 and s1 arvalid together after reset -> s0 granted first, s1 second; repeat -> s0 again (alternation).
- MAX_OUT=4, s0 issues 4 back-to-back ARs, s1 waiting -> all 4 forwarded, s1_arready 0 until 4th RLAST, then s1 granted.
- s0 second AR handshake same cycle as first burst's RLAST -> out_cnt stays 1, DRAIN waits for second RLAST.
- m_rvalid+m_rlast in ARB with no request -> beat sunk (m_rready 1), o_err = 1, persists until arst_n.
- arst_n low in middle of s1 burst -> m_arvalid, s1_rvalid 0 same cycle; after release s0/s1 tie grants s0.
